clk_divider_multi: RTL and testbench
====================================

# clk_divider_multi

Parametrised multi-channel clock divider and tick generator that supersedes the fixed 1 Hz prescaler. Each of N_CH channels divides `clk_in` by a runtime-programmable terminal count and produces both a 50 % square wave and a single-cycle tick strobe. It sits between the board clock and the FSM/display logic, which consumes `tick` as a clock enable.

## Interface
- `N_CH`, default 4: number of independent channels (1..16).
- `CNT_W`, default 26: counter and divisor width in bits.
- `DIV_DEFAULT`, default 49_999_999: reset terminal count. 1 Hz `clk_out` at 100 MHz.
- `SEL_W`, default 2: width of `div_ch`, equal to clog2(N_CH) with a minimum of 1.

- `clk_in`  in  1  system clock (CLK100MHZ); all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  N_CH  per-channel run enable.
- `sync`  in  1  synchronous phase-align strobe for all channels.
- `div_wr`  in  1  divisor write strobe.
- `div_ch`  in  SEL_W  channel addressed by `div_wr`.
- `div_val`  in  CNT_W  terminal count to write. Tick period is div_val+1 cycles.
- `clk_out`  out  N_CH  divided square wave per channel, registered.
- `tick`  out  N_CH  one-cycle strobe per channel at each wrap, registered.

## Operation
- Per-channel state:
  - `cnt[CNT_W]`: counter.
  - `shadow[CNT_W]`: last written divisor.
  - `active[CNT_W]`: divisor in use.
  - `clk_out` bit.
  - `tick` bit.
- Reset (asynchronous) sets, for every channel:
  - `cnt = 0`, `clk_out = 0`, `tick = 0`.
  - `shadow = active = DIV_DEFAULT`.
- Divisor write: if `div_wr = 1` and `div_ch < N_CH`, then `shadow[div_ch] <= div_val`. If `div_ch >= N_CH`, the write is ignored and no state changes.
- Channel running (`enable[i] = 1`, `sync = 0`):
  - If `cnt >= active`, the channel wraps:
    - `cnt <= 0`, `clk_out <= ~clk_out`, `tick <= 1`.
    - `active <= shadow`. If a write to this channel occurs in the same cycle, `active <= div_val` (write bypass).
  - Otherwise `cnt <= cnt + 1` and `tick <= 0`. `active` is unchanged, so a mid-period write takes effect only at the next wrap (glitch-free).
- Channel disabled (`enable[i] = 0`, `sync = 0`):
  - `cnt` and `clk_out` hold their values; `tick <= 0`.
  - `active <= shadow` every cycle, including the write bypass, so a new divisor applies immediately on re-enable.
  - The comparison is `>=` so that a counter left above a reduced divisor wraps on the first enabled cycle.
- Sync (`sync = 1`) overrides `enable` and wrap for all channels:
  - `cnt <= 0`, `clk_out <= 0`, `tick <= 0`.
  - `active <= shadow`, including the write bypass.
- Arithmetic: `cnt` is unsigned, CNT_W bits wide, and never wraps by overflow because `active` is at most 2^CNT_W−1.
- `div_val = 0` is legal: `tick` is held constant at 1 and `clk_out` toggles every cycle (clk_in/2).

## Timing
- Outputs are registered with no combinational path from any input to any output.
- Steady state with terminal count D, measured per channel:
  - `tick` pulses for one cycle every D+1 cycles.
  - `clk_out` has period 2(D+1) cycles and a 50 % duty cycle.
- `tick` is high in the same cycle in which `clk_out` shows its new level.
- First wrap after reset or sync with `enable = 1`: `tick` rises on the (D+1)-th rising edge after `reset`/`sync` is released.
- Divisor write latency:
  - Running channel: the write applies from the wrap following the write.
  - Disabled channel or sync: the write applies one edge later.
- Reset mid-count: all outputs go to 0 immediately, without waiting for a clock edge.
- Channels are fully independent except for the shared `sync` and write port.

## Test plan
- Reset with N_CH=4 and `DIV_DEFAULT` overridden to 9; release reset, `enable = 4'b1111` → every `tick` pulses at cycles 10, 20, 30; `clk_out` = 1 during cycles 10–19 and 0 during cycles 20–29.
- Write ch1 `div_val = 3` at cycle 5 while running with D=9 → ch1 ticks at 10, then 14, 18 (period 4); ch0, ch2 and ch3 are unchanged.
- ch2 at `cnt = 7` with D=9: drop `enable[2]` for 5 cycles, write 4, re-enable → on the first enabled edge `cnt = 7 >= 4`, so ch2 wraps, then ticks every 5 cycles; `clk_out` holds its level while disabled.
- Run channels at different phases, then assert `sync` for one cycle → all `cnt`, `clk_out` and `tick` read 0; with equal D all channels tick on the same cycle D+1 edges later.
- `div_val = 0` on ch3 → `tick[3]` held at 1, `clk_out[3]` toggles every cycle; a write with `div_ch = 5` when N_CH=4 → no state change.
- Assert `reset` asynchronously mid-period and between clock edges → `clk_out` and `tick` go to 0 before the next edge; divisors return to `DIV_DEFAULT`.

Source files
------------

// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider and tick generator. Each channel counts clk_in up to a
// programmable terminal count and emits a 50% square wave plus a one-cycle wrap strobe.
module clk_divider_multi #(
   parameter int               N_CH        = 4,
   parameter int               CNT_W       = 26,
   parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(49_999_999),
   parameter int               SEL_W       = 2
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [N_CH-1:0]   enable,
   input  logic              sync,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] shadow;
      logic [CNT_W-1:0] active;
      logic [CNT_W-1:0] active_nxt;
      logic             clk_q;
      logic             tick_q;
      logic             wr_hit;

      // Addresses at or beyond N_CH match no channel, so such writes are dropped.
      assign wr_hit     = div_wr && (32'(div_ch) == 32'(i));
      assign active_nxt = wr_hit ? div_val : shadow;

      always_ff @(posedge clk_in or posedge reset) begin
         if (reset) begin
            shadow <= DIV_DEFAULT;
         end else if (wr_hit) begin
            shadow <= div_val;
         end
      end

      always_ff @(posedge clk_in or posedge reset) begin
         if (reset) begin
            cnt    <= '0;
            active <= DIV_DEFAULT;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (sync) begin
            cnt    <= '0;
            active <= active_nxt;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (enable[i]) begin
            // >= lets a counter stranded above a shrunken divisor wrap at once.
            if (cnt >= active) begin
               cnt    <= '0;
               active <= active_nxt;
               clk_q  <= ~clk_q;
               tick_q <= 1'b1;
            end else begin
               cnt    <= cnt + 1'b1;
               tick_q <= 1'b0;
            end
         end else begin
            active <= active_nxt;
            tick_q <= 1'b0;
         end
      end

      assign clk_out[i] = clk_q;
      assign tick[i]    = tick_q;
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: four channels, reset divisor 9, 3-bit channel
// select so that out-of-range addresses can be driven.
module tb_clk_divider_multi;

   localparam int N_CH  = 4;
   localparam int CNT_W = 26;
   localparam int SEL_W = 3;

   logic              clk_in = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   enable;
   logic              sync;
   logic              div_wr;
   logic [SEL_W-1:0]  div_ch;
   logic [CNT_W-1:0]  div_val;
   logic [N_CH-1:0]   clk_out;
   logic [N_CH-1:0]   tick;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   clk_divider_multi #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(26'd9),
      .SEL_W      (SEL_W)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .enable (enable),
      .sync   (sync),
      .div_wr (div_wr),
      .div_ch (div_ch),
      .div_val(div_val),
      .clk_out(clk_out),
      .tick   (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic write(input int ch, input int val);
      div_wr  = 1'b1;
      div_ch  = SEL_W'(ch);
      div_val = CNT_W'(val);
      step();
      div_wr  = 1'b0;
   endtask

   initial begin
      int base;
      logic [3:0] exp_t;
      logic [3:0] exp_c;
      logic       c1;

      reset   = 1'b1;
      enable  = '0;
      sync    = 1'b0;
      div_wr  = 1'b0;
      div_ch  = '0;
      div_val = '0;
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_clk_out", 32'(clk_out), 32'h0);
      check("reset_tick",    32'(tick),    32'h0);

      // Default divisor 9 on all channels; ch1 reprogrammed to 3 at edge 5.
      @(negedge clk_in);
      reset  = 1'b0;
      enable = 4'b1111;
      cyc    = 0;
      c1     = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5) begin
            div_wr = 1'b1; div_ch = 3'd1; div_val = 26'd3;
         end
         step();
         div_wr = 1'b0;
         exp_t = (c % 10 == 0) ? 4'b1101 : 4'b0000;
         exp_c = ((c / 10) % 2 == 1) ? 4'b1101 : 4'b0000;
         if (c == 10 || (c > 10 && (c - 10) % 4 == 0)) begin
            exp_t[1] = 1'b1;
            c1 = ~c1;
         end
         exp_c[1] = c1;
         check("run_tick",    32'(tick),    32'(exp_t));
         check("run_clk_out", 32'(clk_out), 32'(exp_c));
      end

      // ch2 sits at cnt=7 after cycle 37; disable it for edges 38..42, write 4 meanwhile.
      repeat (7) step();
      enable[2] = 1'b0;
      repeat (2) begin
         step();
         check("dis_tick2", 32'(tick[2]),    32'h0);
         check("dis_clk2",  32'(clk_out[2]), 32'h1);
      end
      write(2, 4);
      check("dis_tick2", 32'(tick[2]),    32'h0);
      check("dis_clk2",  32'(clk_out[2]), 32'h1);
      repeat (2) begin
         step();
         check("dis_tick2", 32'(tick[2]),    32'h0);
         check("dis_clk2",  32'(clk_out[2]), 32'h1);
      end
      enable[2] = 1'b1;
      for (int c = 43; c <= 53; c++) begin
         step();
         check("reen_tick2", 32'(tick[2]), (c == 43 || c == 48 || c == 53) ? 32'h1 : 32'h0);
         check("reen_clk2",  32'(clk_out[2]), (c >= 48 && c < 53) ? 32'h1 : 32'h0);
      end

      // Equalise divisors, then sync: every channel should tick together 10 edges later.
      write(1, 9);
      write(2, 9);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_tick",    32'(tick),    32'h0);
      check("sync_clk_out", 32'(clk_out), 32'h0);
      for (int k = 1; k <= 10; k++) begin
         step();
         check("post_sync_tick", 32'(tick),    (k == 10) ? 32'hf : 32'h0);
         check("post_sync_clk",  32'(clk_out), (k == 10) ? 32'hf : 32'h0);
      end

      // ch3 at terminal count 0, applied immediately by a sync.
      write(3, 0);
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         check("div0_tick3", 32'(tick[3]),    32'h1);
         check("div0_clk3",  32'(clk_out[3]), (k % 2 == 1) ? 32'h1 : 32'h0);
      end

      // Out-of-range channel addresses 5 and 4 must not alias onto ch1/ch0.
      write(5, 2);
      write(4, 2);
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         check("oor_tick", 32'(tick), (k == 10) ? 32'hf : 32'h8);
      end

      // Asynchronous reset between edges, with ch3 still toggling every cycle.
      #2;
      check("pre_rst_tick3", 32'(tick[3]), 32'h1);
      reset = 1'b1;
      #1;
      check("async_rst_clk_out", 32'(clk_out), 32'h0);
      check("async_rst_tick",    32'(tick),    32'h0);
      @(negedge clk_in);
      reset = 1'b0;
      base  = cyc;
      for (int k = 1; k <= 10; k++) begin
         step();
         check("rst_default_tick", 32'(tick), (k == 10) ? 32'hf : 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
